// File: rtl/fb_pixel_writer_if.sv
// Plot stream, clear control and framebuffer write bus for fb_pixel_writer.
// The slave side is the pixel writer. The master side is the drawing logic together with the RAM.
interface fb_pixel_writer_if #(
    parameter int COLOUR_W = 3,
    parameter int ADDR_W   = 15
);
    logic                plot_valid;
    logic                plot_ready;
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour_in;
    logic                clear_req;
    logic [COLOUR_W-1:0] clear_colour;
    logic                busy;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [COLOUR_W-1:0] wr_data;

    modport master (
        output plot_valid, x, y, colour_in, clear_req, clear_colour,
        input  plot_ready, busy, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  plot_valid, x, y, colour_in, clear_req, clear_colour,
        output plot_ready, busy, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: plot requests become linear RAM writes, and a clear sweep fills the whole buffer.
// Defining FB_DROP_COUNT_EN adds a saturating counter of out-of-range plots on the drop_count port.
module fb_pixel_writer #(
    parameter int H_RES    = 160,
    parameter int V_RES    = 120,
    parameter int COLOUR_W = 3,
    parameter int ADDR_W   = 15
) (
    input  logic               clk,
    input  logic               rst,
    fb_pixel_writer_if.slave   bus
`ifdef FB_DROP_COUNT_EN
    ,
    output logic [15:0]        drop_count
`endif
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [COLOUR_W-1:0] clr_colour;
    logic                in_range;
    logic [ADDR_W-1:0]   plot_addr;

    assign bus.plot_ready = (state == IDLE);
    assign in_range  = (int'(bus.x) < H_RES) && (int'(bus.y) < V_RES);
    assign plot_addr = ADDR_W'(int'(bus.y) * H_RES + int'(bus.x));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.clear_req) state_nxt = CLEAR;
            CLEAR:   if (clr_cnt == LAST_ADDR) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.busy    <= 1'b0;
            clr_cnt     <= '0;
            clr_colour  <= '0;
        end else begin
            state     <= state_nxt;
            bus.wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    // A plot accepted at the clear-entry edge is written ahead of the sweep.
                    if (bus.plot_valid && in_range) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= plot_addr;
                        bus.wr_data <= bus.colour_in;
                    end
                    if (bus.clear_req) begin
                        clr_colour <= bus.clear_colour;
                        clr_cnt    <= '0;
                        bus.busy   <= 1'b1;
                    end
                end
                CLEAR: begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= clr_cnt;
                    bus.wr_data <= clr_colour;
                    clr_cnt     <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) bus.busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef FB_DROP_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_count <= '0;
        else if (state == IDLE && bus.plot_valid && !in_range && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end
`endif
endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Receiving end of the x/y/colour pixel stream produced by the screen-drawing blocks.
- Accepts plot requests over a valid/ready handshake and turns each in-range (x, y) into a linear framebuffer address (y*H_RES + x).
- Drives a single-port write interface into a 160x120, 3-bit framebuffer RAM of the same kind as the title and game-over RAMs.
- Also provides a bulk-clear sequencer that fills the whole buffer with one colour, used between title, game and game-over screens.

Parameters:
- H_RES, 160, horizontal resolution in pixels.
- V_RES, 120, vertical resolution in pixels.
- COLOUR_W, 3, colour width in bits (RGB, one bit each).
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- plot_valid, input, 1, plot request present.
- plot_ready, output, 1, block can accept a plot this cycle.
- x, input, 8, pixel column.
- y, input, 7, pixel row.
- colour_in, input, COLOUR_W, pixel colour.
- clear_req, input, 1, start a full-buffer clear (level sampled).
- clear_colour, input, COLOUR_W, fill colour for the clear.
- busy, output, 1, clear sweep in progress.
- wr_en, output, 1, framebuffer write strobe.
- wr_addr, output, ADDR_W, framebuffer write address.
- wr_data, output, COLOUR_W, framebuffer write data.
- drop_count, output, 16, out-of-range plot counter (present only with the optional feature).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst).
- Reset values: state IDLE; wr_en 0; wr_addr 0; wr_data 0; busy 0; plot_ready 1 once rst deasserts; clear counter 0; drop_count 0.
- States: IDLE and CLEAR.
- plot_ready = (state == IDLE). It is combinational from state only and never depends on plot_valid or clear_req.
- Plot acceptance: a plot is accepted at the rising edge where plot_valid && plot_ready.
- Plot outputs: all outputs are registered, so latency is 1 cycle.
  - In range (x < H_RES and y < V_RES): in the cycle after the accepting edge, wr_en=1, wr_addr = y*H_RES + x, wr_data = colour_in.
  - Out of range: the plot is still accepted (handshake completes) but wr_en stays 0 and nothing is written.
- Address arithmetic: computed at full width and truncated to ADDR_W. The maximum legal address is 19199.
- Back-to-back plots: one per cycle, sustained.
- Clear entry: clear_req sampled high at an edge in IDLE:
  - latch clear_colour;
  - clear counter <= 0;
  - state <= CLEAR;
  - busy <= 1 at the same edge.
- Clear with simultaneous plot: if plot_valid is also high at that edge, the plot is accepted and its write appears in the next cycle, i.e. before any clear write.
- Clear sweep: at each edge in CLEAR, wr_en<=1, wr_addr<=counter, wr_data<=latched colour, counter<=counter+1.
  - At the edge that issues address H_RES*V_RES-1: state<=IDLE, busy<=0.
  - The sweep is exactly 19200 consecutive write cycles covering addresses 0..19199, each exactly once, in ascending order.
- Clear_req while in CLEAR: ignored, no restart.
- Clear_req held high through the return to IDLE: starts a new clear at the first IDLE edge.
- wr_en: low in every cycle not listed above.
- Reset mid-sweep: immediately returns to IDLE with all outputs at their reset values. The partial clear is not resumed.

Optional Feature:
- Macro: FB_DROP_COUNT_EN.
- With the macro defined:
  - drop_count port exists;
  - it increments on each accepted out-of-range plot;
  - it saturates at 16'hFFFF;
  - it resets only on rst.
- Without the macro: the port and counter are absent. Out-of-range plots are silently discarded with identical handshake timing.

Test Plan:
- Reset release, plot_valid=1 with x=0, y=0, colour=3'b100 -> plot_ready=1; next cycle wr_en=1, wr_addr=0, wr_data=3'b100.
- Four back-to-back plots (159,0), (0,1), (159,119), (10,5) -> wr_addr 159, 160, 19199, 810 on consecutive cycles, wr_en continuously high.
- Plots at (160,0) and (0,120) -> accepted (plot_ready=1), wr_en=0. With FB_DROP_COUNT_EN, drop_count=2.
- clear_req pulse with clear_colour=3'b000 and a simultaneous plot at (5,5) colour 3'b010 -> first write addr 805 data 010.
  - Then 19200 writes, addr 0..19199, data 000.
  - busy and plot_ready low for exactly 19200 cycles, then plot_ready=1.
- Assert rst at clear write 5000 -> wr_en=0, busy=0 asynchronously. After release, plot_ready=1 and no further clear writes occur.
- With FB_DROP_COUNT_EN, 65537 out-of-range plots -> drop_count=16'hFFFF.
